store_narrow_unit: RTL and testbench
====================================

Name: store_narrow_unit

Overview:
- Store-side counterpart of the datapath's 16→32 sign-extension path: takes a 32-bit register value and narrows it to byte, halfword or word.
- Merges the narrowed value into word-addressed data memory with a read-modify-write sequence.
- Sits between the CPU store path and the data memory.
- Flags values that do not round-trip through sign extension of the stored width.

Parameters:
- READ_LAT, 1, cycles from the mem_rd_en cycle until mem_rdata is valid (≥1).
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  store request; sampled only in IDLE.
- size  in  2  00 = byte, 01 = halfword, 10 = word, 11 = illegal.
- addr  in  ADDR_W  byte address; captured at start.
- wdata  in  32  register value to store; captured at start.
- busy  out  1  high while a request is in flight.
- done  out  1  one-cycle completion pulse.
- misaligned  out  1  one-cycle error pulse, coincident with done.
- trunc_ovf  out  1  valid with done: narrowed value ≠ original under sign extension.
- mem_addr  out  ADDR_W-2  word address = captured addr[ADDR_W-1:2].
- mem_rd_en  out  1  read strobe, exactly one cycle.
- mem_rdata  in  32  read data.
- mem_wr_en  out  1  write strobe, exactly one cycle.
- mem_wdata  out  32  merged write word.

Behaviour:
- Reset (async, reset_n = 0): state IDLE; busy, done, misaligned, trunc_ovf, mem_rd_en, mem_wr_en = 0; mem_addr, mem_wdata = 0.
  - Reset mid-operation aborts immediately.
  - No write strobe is issued after reset asserts; the pending request is discarded.
- States: IDLE, READ, WAIT, WRITE, DONE.
- IDLE, start = 1 at cycle T: capture addr, size, wdata.
  - Illegal size, or misaligned access (half with addr[0] = 1; word with addr[1:0] ≠ 0): at T+1 pulse done = 1 and misaligned = 1; no memory access; busy stays 0; remain in IDLE.
  - Word: go to WRITE. T+1: mem_wr_en = 1, mem_wdata = wdata, busy = 1. T+2: done = 1, busy = 0.
  - Byte/half: go to READ. T+1: mem_rd_en = 1, busy = 1.
- WAIT: READ_LAT cycles. mem_rdata is valid in cycle T+1+READ_LAT and is registered at the end of that cycle.
- WRITE at T+2+READ_LAT: mem_wr_en = 1, mem_wdata = merged word.
- DONE at T+3+READ_LAT: done = 1, busy = 0, then return to IDLE.
- Merge rule (little-endian):
  - Byte: lane k = addr[1:0] gets wdata[7:0] in bits [8k+7:8k]; other bytes unchanged from the read word.
  - Half: lane h = addr[1] gets wdata[15:0] in bits [16h+15:16h].
- trunc_ovf, registered, valid only with done:
  - Byte: 1 if wdata[31:7] is not all-equal.
  - Half: 1 if wdata[31:15] is not all-equal.
  - Word or error: 0.
  - Informational only; the store still completes.
- mem_addr is held stable from the cycle after start until DONE.
- start while busy, or in a DONE/error-pulse cycle, is ignored (not queued).
- Back-to-back: a new start is accepted the cycle after done.
- done, misaligned and trunc_ovf are 0 in all cycles other than the done pulse.

Test Plan:
- Byte store: memory word 0x10 = 0x11223344, SB addr 0x41, wdata 0x000000AB, READ_LAT = 1 → rd_en at T+1, write 0x1122AB44 at T+3, done at T+4, trunc_ovf = 1.
- Byte store, sign-representable: SB addr 0x40, wdata 0xFFFFFF80 → write 0x11223380, trunc_ovf = 0.
- Half store: SH addr 0x42, wdata 0xFFFF8001 → write 0x80013344, trunc_ovf = 0. Repeat with wdata 0x00018001 → trunc_ovf = 1.
- Word store: SW addr 0x44, wdata 0xDEADBEEF → no rd_en, write at T+1, done at T+2.
- Error cases: SH addr 0x43 → done = misaligned = 1 at T+1, no rd/wr strobes. Same for size = 11.
- Reset and start-while-busy:
  - Assert reset_n = 0 during WAIT of an SB → all outputs 0 immediately, no wr_en ever, next start completes normally.
  - start pulsed while busy → ignored, memory unchanged by it.

Source files
------------

// File: rtl/store_narrow_unit.sv
// Store narrowing unit: narrows a register value to byte/half/word and merges it into
// word-addressed memory with a read-modify-write, flagging values that lose information.
module store_narrow_unit #(
  parameter int READ_LAT = 1,
  parameter int ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        size,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              misaligned,
  output logic              trunc_ovf,
  output logic [ADDR_W-3:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rdata,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        state_dbg
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam int CW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic          half_q;
  logic [1:0]    lane_q;
  logic [15:0]   wdata_q;
  logic          ovf_q;

  logic          size_ok;
  logic          ovf_now;
  logic [31:0]   merged;

  assign state_dbg = state;

  // Legality and round-trip check on the live request, latched only when accepted.
  always_comb begin
    size_ok = 1'b0;
    ovf_now = 1'b0;
    case (size)
      2'b00: begin
        size_ok = 1'b1;
        ovf_now = !((&wdata[31:7]) || (~|wdata[31:7]));
      end
      2'b01: begin
        size_ok = !addr[0];
        ovf_now = !((&wdata[31:15]) || (~|wdata[31:15]));
      end
      2'b10:   size_ok = (addr[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
  end

  // Little-endian lane merge of the narrowed value into the word just read.
  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      if (lane_q[1]) merged[31:16] = wdata_q;
      else           merged[15:0]  = wdata_q;
    end else begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      half_q     <= 1'b0;
      lane_q     <= 2'b00;
      wdata_q    <= '0;
      ovf_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      misaligned <= 1'b0;
      trunc_ovf  <= 1'b0;
      mem_addr   <= '0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      done       <= 1'b0;
      misaligned <= 1'b0;
      trunc_ovf  <= 1'b0;
      mem_rd_en  <= 1'b0;
      mem_wr_en  <= 1'b0;
      case (state)
        S_IDLE: begin
          // A start during the error pulse cycle is dropped, not queued.
          if (start && !done) begin
            if (!size_ok) begin
              done       <= 1'b1;
              misaligned <= 1'b1;
            end else begin
              mem_addr <= addr[ADDR_W-1:2];
              busy     <= 1'b1;
              half_q   <= size[0];
              lane_q   <= addr[1:0];
              wdata_q  <= wdata[15:0];
              ovf_q    <= ovf_now;
              if (size == 2'b10) begin
                mem_wr_en <= 1'b1;
                mem_wdata <= wdata;
                state     <= S_WRITE;
              end else begin
                mem_rd_en <= 1'b1;
                state     <= S_READ;
              end
            end
          end
        end
        S_READ: begin
          cnt   <= CW'(READ_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == '0) begin
            mem_wdata <= merged;
            mem_wr_en <= 1'b1;
            state     <= S_WRITE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_WRITE: begin
          done      <= 1'b1;
          trunc_ovf <= ovf_q;
          busy      <= 1'b0;
          state     <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Directed bench for store_narrow_unit: a driver pushes expected completions into a queue,
// a monitor pops and compares them at each done pulse against a small memory model.
module tb_store_narrow_unit;
  localparam int ADDR_W = 32;

  typedef struct packed {
    logic        mis;
    logic        ovf;
    logic [3:0]  lat;
    logic [1:0]  nrd;
    logic [1:0]  nwr;
    logic [29:0] waddr;
    logic [31:0] wword;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [1:0]        size = 2'b00;
  logic [ADDR_W-1:0] addr = '0;
  logic [31:0]       wdata = '0;
  logic              busy, done, misaligned, trunc_ovf;
  logic [ADDR_W-3:0] mem_addr;
  logic              mem_rd_en, mem_wr_en;
  logic [31:0]       mem_rdata, mem_wdata;
  logic [2:0]        state_dbg;

  logic [31:0] mem [0:63];
  logic [31:0] rdata_q = '0;
  logic        load_en = 1'b0;
  logic [5:0]  load_idx = '0;
  logic [31:0] load_val = '0;

  exp_t exp_q[$];
  int   cyc = 0;
  int   start_cyc = 0;
  int   checks = 0;
  int   failures = 0;

  store_narrow_unit #(.READ_LAT(1), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .size(size), .addr(addr), .wdata(wdata),
    .busy(busy), .done(done), .misaligned(misaligned), .trunc_ovf(trunc_ovf),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Memory model with one cycle of read latency.
  assign mem_rdata = rdata_q;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_rd_en) rdata_q <= mem[mem_addr[5:0]];
    if (mem_wr_en) mem[mem_addr[5:0]] <= mem_wdata;
    if (load_en)   mem[load_idx] <= load_val;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic mis, input logic ovf, input int lat, input int nrd,
                              input int nwr, input logic [29:0] waddr, input logic [31:0] wword);
    exp_t e;
    e.mis = mis; e.ovf = ovf; e.lat = 4'(lat); e.nrd = 2'(nrd); e.nwr = 2'(nwr);
    e.waddr = waddr; e.wword = wword;
    return e;
  endfunction

  // Monitor: counts strobes per transaction and checks each done pulse against the queue.
  initial begin
    int   nrd = 0;
    int   nwr = 0;
    logic [29:0] waddr_s = '0;
    logic [31:0] wword_s = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        nrd = 0;
        nwr = 0;
      end else begin
        if (mem_rd_en) nrd++;
        if (mem_wr_en) begin
          nwr++;
          waddr_s = mem_addr;
          wword_s = mem_wdata;
        end
        if (!done) check("flags_outside_done", {30'd0, misaligned, trunc_ovf}, 32'd0);
        if (done) begin
          if (exp_q.size() == 0) begin
            check("unexpected_done", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("misaligned", {31'd0, misaligned}, {31'd0, e.mis});
            check("trunc_ovf", {31'd0, trunc_ovf}, {31'd0, e.ovf});
            check("latency", 32'(cyc - start_cyc), {28'd0, e.lat});
            check("rd_strobes", 32'(nrd), {30'd0, e.nrd});
            check("wr_strobes", 32'(nwr), {30'd0, e.nwr});
            if (e.nwr != 2'd0) begin
              check("wr_addr", {2'b00, waddr_s}, {2'b00, e.waddr});
              check("wr_word", wword_s, e.wword);
            end
          end
          nrd = 0;
          nwr = 0;
        end
      end
    end
  end

  task automatic set_mem(input logic [5:0] idx, input logic [31:0] val);
    @(negedge clk);
    load_en = 1'b1; load_idx = idx; load_val = val;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  task automatic issue(input logic [1:0] s, input logic [31:0] a, input logic [31:0] d,
                       input exp_t e, input int hold = 1);
    @(negedge clk);
    size = s; addr = a; wdata = d; start = 1'b1;
    start_cyc = cyc;
    exp_q.push_back(e);
    repeat (hold) @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    int i;
    for (i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      check("timeout", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic check_quiet(input string name);
    check({name, "_flags"}, {25'd0, busy, done, misaligned, trunc_ovf, mem_rd_en, mem_wr_en,
                             1'b0}, 32'd0);
    check({name, "_state"}, {29'd0, state_dbg}, 32'd0);
    check({name, "_mem_addr"}, {2'b00, mem_addr}, 32'd0);
    check({name, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_quiet("reset");
    reset_n = 1'b1;
    set_mem(6'h10, 32'h11223344);
    set_mem(6'h11, 32'h00000000);

    issue(2'b00, 32'h41, 32'h000000AB, mk(0, 1, 4, 1, 1, 30'h10, 32'h1122AB44));
    wait_idle();
    set_mem(6'h10, 32'h11223344);
    issue(2'b00, 32'h40, 32'hFFFFFF80, mk(0, 0, 4, 1, 1, 30'h10, 32'h11223380));
    wait_idle();
    set_mem(6'h10, 32'h11223344);
    issue(2'b01, 32'h42, 32'hFFFF8001, mk(0, 0, 4, 1, 1, 30'h10, 32'h80013344));
    wait_idle();
    set_mem(6'h10, 32'h11223344);
    issue(2'b01, 32'h42, 32'h00018001, mk(0, 1, 4, 1, 1, 30'h10, 32'h80013344));
    wait_idle();
    set_mem(6'h10, 32'h11223344);
    issue(2'b10, 32'h44, 32'hDEADBEEF, mk(0, 0, 2, 0, 1, 30'h11, 32'hDEADBEEF));
    wait_idle();

    // Error cases; the first holds start through its own error pulse, which must be dropped.
    issue(2'b01, 32'h43, 32'h00001234, mk(1, 0, 1, 0, 0, 30'h0, 32'h0), 2);
    wait_idle();
    issue(2'b11, 32'h40, 32'h00000055, mk(1, 0, 1, 0, 0, 30'h0, 32'h0));
    wait_idle();
    issue(2'b10, 32'h46, 32'h12345678, mk(1, 0, 1, 0, 0, 30'h0, 32'h0));
    wait_idle();

    // Back-to-back: each start lands in the cycle after the previous done.
    issue(2'b00, 32'h43, 32'h00000012, mk(0, 0, 4, 1, 1, 30'h10, 32'h12223344));
    wait_idle();
    issue(2'b01, 32'h40, 32'h00007FFF, mk(0, 0, 4, 1, 1, 30'h10, 32'h12227FFF));
    wait_idle();
    set_mem(6'h10, 32'h11223344);

    // Reset during WAIT of a byte store: outputs clear at once and no write follows.
    @(negedge clk);
    size = 2'b00; addr = 32'h41; wdata = 32'h00000055; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #1 reset_n = 1'b0;
    #1 check_quiet("abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_mem_kept", mem[6'h10], 32'h11223344);
    issue(2'b00, 32'h41, 32'h000000AB, mk(0, 1, 4, 1, 1, 30'h10, 32'h1122AB44));
    wait_idle();
    set_mem(6'h10, 32'h11223344);

    // A start pulsed while busy is ignored.
    issue(2'b00, 32'h40, 32'h00000001, mk(0, 0, 4, 1, 1, 30'h10, 32'h11223301));
    size = 2'b00; addr = 32'h41; wdata = 32'h000000FF; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle();
    repeat (10) @(negedge clk);
    check("busy_start_mem", mem[6'h10], 32'h11223301);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
